vga_timing_ctrl: RTL and testbench

//  Upstream timing/sequencing stage for the RGB frame memory. After reset it first sweeps the

---
 rtl/vga_timing_if.sv | 23 ++
 rtl/vga_timing_ctrl.sv | 104 ++++++++++
 tb/tb_vga_timing_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - raster/memory-clear output bundle of the VGA timing controller
interface vga_timing_if #(
    parameter int X_W = 11,
    parameter int Y_W = 10,
    parameter int A_W = 10
) ();
    logic [X_W-1:0] hpos;
    logic [Y_W-1:0] vpos;
    logic           display_on;
    logic           hsync;
    logic           vsync;
    logic           frame_start;
    logic [A_W-1:0] resetcnt;
    logic           memreset;

    modport master (
        output hpos, vpos, display_on, hsync, vsync, frame_start, resetcnt, memreset
    );

    modport slave (
        input hpos, vpos, display_on, hsync, vsync, frame_start, resetcnt, memreset
    );
endinterface

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - frame-memory clear sweep then VGA raster timing; MEMCLEAR_EN enables the clear sweep
module vga_timing_ctrl #(
    parameter int RESOLUTION_H = 1280,
    parameter int RESOLUTION_V = 960,
    parameter int H_FRONT      = 80,
    parameter int H_SYNC       = 136,
    parameter int H_BACK       = 216,
    parameter int V_BOTTOM     = 1,
    parameter int V_SYNC       = 3,
    parameter int V_TOP        = 30,
    parameter int ADDR_WIDTH   = 10,
    parameter int CLEAR_DEPTH  = 800
) (
    input  logic         clk,
    input  logic         reset,
    vga_timing_if.master bus
);
    localparam int H_TOTAL      = RESOLUTION_H + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = RESOLUTION_V + V_BOTTOM + V_SYNC + V_TOP;
    localparam int X_WIRE_WIDTH = $clog2(H_TOTAL);
    localparam int Y_WIRE_WIDTH = $clog2(V_TOTAL);

    localparam logic [X_WIRE_WIDTH-1:0] H_LAST     = X_WIRE_WIDTH'(H_TOTAL - 1);
    localparam logic [X_WIRE_WIDTH-1:0] H_ACT_END  = X_WIRE_WIDTH'(RESOLUTION_H);
    localparam logic [X_WIRE_WIDTH-1:0] H_SYNC_BEG = X_WIRE_WIDTH'(RESOLUTION_H + H_FRONT);
    localparam logic [X_WIRE_WIDTH-1:0] H_SYNC_END = X_WIRE_WIDTH'(RESOLUTION_H + H_FRONT + H_SYNC);
    localparam logic [Y_WIRE_WIDTH-1:0] V_LAST     = Y_WIRE_WIDTH'(V_TOTAL - 1);
    localparam logic [Y_WIRE_WIDTH-1:0] V_ACT_END  = Y_WIRE_WIDTH'(RESOLUTION_V);
    localparam logic [Y_WIRE_WIDTH-1:0] V_SYNC_BEG = Y_WIRE_WIDTH'(RESOLUTION_V + V_BOTTOM);
    localparam logic [Y_WIRE_WIDTH-1:0] V_SYNC_END = Y_WIRE_WIDTH'(RESOLUTION_V + V_BOTTOM + V_SYNC);

`ifdef MEMCLEAR_EN
    localparam logic [ADDR_WIDTH-1:0] CLEAR_LAST = ADDR_WIDTH'(CLEAR_DEPTH - 1);
    // memory stays held in clear until the sweep finishes
    localparam logic MEMRESET_INIT = 1'b0;
`else
    // no sweep: memory is usable straight out of reset
    localparam logic MEMRESET_INIT = 1'b1;
`endif

    // ST_INIT is the post-reset state: the clear sweep when enabled, otherwise a single cycle
    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                  state;
    logic [X_WIRE_WIDTH-1:0] next_h;
    logic [Y_WIRE_WIDTH-1:0] next_v;
    logic                    run_next;

    // next-state raster counters; decodes use these so they line up with the registered counters
    always_comb begin
        next_h   = '0;
        next_v   = '0;
        run_next = 1'b0;
        if (state == ST_RUN) begin
            run_next = 1'b1;
            if (bus.hpos == H_LAST) begin
                next_h = '0;
                next_v = (bus.vpos == V_LAST) ? '0 : bus.vpos + 1'b1;
            end else begin
                next_h = bus.hpos + 1'b1;
                next_v = bus.vpos;
            end
        end else begin
`ifdef MEMCLEAR_EN
            run_next = (bus.resetcnt == CLEAR_LAST);
`else
            run_next = 1'b1;
`endif
        end
    end

    // state, counters and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_INIT;
            bus.hpos        <= '0;
            bus.vpos        <= '0;
            bus.display_on  <= 1'b0;
            bus.hsync       <= 1'b1;
            bus.vsync       <= 1'b1;
            bus.frame_start <= 1'b0;
            bus.resetcnt    <= '0;
            bus.memreset    <= MEMRESET_INIT;
        end else if (run_next) begin
            state           <= ST_RUN;
            bus.hpos        <= next_h;
            bus.vpos        <= next_v;
            bus.display_on  <= (next_h < H_ACT_END) && (next_v < V_ACT_END);
            bus.hsync       <= !((next_h >= H_SYNC_BEG) && (next_h < H_SYNC_END));
            bus.vsync       <= !((next_v >= V_SYNC_BEG) && (next_v < V_SYNC_END));
            bus.frame_start <= (next_h == '0) && (next_v == '0);
            bus.memreset    <= 1'b1;
        end else begin
`ifdef MEMCLEAR_EN
            bus.resetcnt    <= bus.resetcnt + 1'b1;
`else
            bus.resetcnt    <= '0;
`endif
        end
    end
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - scoreboard bench for vga_timing_ctrl, full-size and shrunken raster
module tb_vga_timing_ctrl;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

`ifdef MEMCLEAR_EN
    localparam int SA = 800;
    localparam int SB = 20;
    localparam int RC_A = 799;
    localparam int RC_B = 19;
    localparam bit MR0 = 1'b0;
`else
    localparam int SA = 1;
    localparam int SB = 1;
    localparam int RC_A = 0;
    localparam int RC_B = 0;
    localparam bit MR0 = 1'b1;
`endif

    vga_timing_if #(.X_W(11), .Y_W(10), .A_W(10)) bus_a ();
    vga_timing_if #(.X_W(5), .Y_W(4), .A_W(5)) bus_b ();

    vga_timing_ctrl dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    // 25 clocks per line (16 active, hsync low 18..20), 12 lines per frame (6 active, vsync low 7..9)
    vga_timing_ctrl #(
        .RESOLUTION_H (16),
        .RESOLUTION_V (6),
        .H_FRONT      (2),
        .H_SYNC       (3),
        .H_BACK       (4),
        .V_BOTTOM     (1),
        .V_SYNC       (3),
        .V_TOP        (2),
        .ADDR_WIDTH   (5),
        .CLEAR_DEPTH  (20)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    typedef struct {
        string name;
        bit    which;
        int    h;
        int    v;
        bit    disp;
        bit    hs;
        bit    vs;
        bit    fs;
        int    rc;
        bit    mr;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int edges = 0;

    task automatic want(input string name, input bit which, input int h, input int v,
                        input bit disp, input bit hs, input bit vs, input bit fs,
                        input int rc, input bit mr);
        exp_t e;
        e.name = name; e.which = which; e.h = h; e.v = v;
        e.disp = disp; e.hs = hs; e.vs = vs; e.fs = fs; e.rc = rc; e.mr = mr;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            edges++;
        end
        #1;
    endtask

    task automatic run_to(input int target);
        while (edges < target) step(1);
    endtask

    // monitor: outputs are presented every cycle, compare queued expectations at the falling edge
    always @(negedge clk) begin
        exp_t e;
        int ah, av, arc;
        logic ad, ahs, avs, afs, amr;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (!e.which) begin
                ah = int'(bus_a.hpos); av = int'(bus_a.vpos); arc = int'(bus_a.resetcnt);
                ad = bus_a.display_on; ahs = bus_a.hsync; avs = bus_a.vsync;
                afs = bus_a.frame_start; amr = bus_a.memreset;
            end else begin
                ah = int'(bus_b.hpos); av = int'(bus_b.vpos); arc = int'(bus_b.resetcnt);
                ad = bus_b.display_on; ahs = bus_b.hsync; avs = bus_b.vsync;
                afs = bus_b.frame_start; amr = bus_b.memreset;
            end
            total++;
            if (ah != e.h || av != e.v || arc != e.rc || ad !== e.disp || ahs !== e.hs ||
                avs !== e.vs || afs !== e.fs || amr !== e.mr) begin
                bad++;
                $display("FAIL %s: got h=%0d v=%0d disp=%b hs=%b vs=%b fs=%b rc=%0d mr=%b want h=%0d v=%0d disp=%b hs=%b vs=%b fs=%b rc=%0d mr=%b",
                         e.name, ah, av, ad, ahs, avs, afs, arc, amr,
                         e.h, e.v, e.disp, e.hs, e.vs, e.fs, e.rc, e.mr);
            end
        end
    end

    initial begin
        // reset held for two clocks on both instances
        step(2);
        want("a_reset", 0, 0, 0, 0, 1, 1, 0, 0, MR0);
        want("b_reset", 1, 0, 0, 0, 1, 1, 0, 0, MR0);

        // shrunken raster: frame-level boundaries
        rst_b = 1'b0;
        edges = 0;
`ifdef MEMCLEAR_EN
        step(1);
        want("b_clear_first", 1, 0, 0, 0, 1, 1, 0, 1, 0);
        run_to(19);
        want("b_clear_last", 1, 0, 0, 0, 1, 1, 0, 19, 0);
`endif
        run_to(SB);       want("b_run_entry", 1, 0, 0, 1, 1, 1, 1, RC_B, 1);
        run_to(SB + 1);   want("b_h1", 1, 1, 0, 1, 1, 1, 0, RC_B, 1);
        run_to(SB + 17);  want("b_h17", 1, 17, 0, 0, 1, 1, 0, RC_B, 1);
        run_to(SB + 18);  want("b_hsync_beg", 1, 18, 0, 0, 0, 1, 0, RC_B, 1);
        run_to(SB + 20);  want("b_hsync_end", 1, 20, 0, 0, 0, 1, 0, RC_B, 1);
        run_to(SB + 21);  want("b_hsync_off", 1, 21, 0, 0, 1, 1, 0, RC_B, 1);
        run_to(SB + 140); want("b_last_act", 1, 15, 5, 1, 1, 1, 0, RC_B, 1);
        run_to(SB + 149); want("b_line5_end", 1, 24, 5, 0, 1, 1, 0, RC_B, 1);
        run_to(SB + 150); want("b_v6_start", 1, 0, 6, 0, 1, 1, 0, RC_B, 1);
        run_to(SB + 174); want("b_v6_end", 1, 24, 6, 0, 1, 1, 0, RC_B, 1);
        run_to(SB + 175); want("b_vsync_beg", 1, 0, 7, 0, 1, 0, 0, RC_B, 1);
        run_to(SB + 219); want("b_both_sync", 1, 19, 8, 0, 0, 0, 0, RC_B, 1);
        run_to(SB + 249); want("b_vsync_end", 1, 24, 9, 0, 1, 0, 0, RC_B, 1);
        run_to(SB + 250); want("b_vsync_off", 1, 0, 10, 0, 1, 1, 0, RC_B, 1);
        run_to(SB + 299); want("b_frame_last", 1, 24, 11, 0, 1, 1, 0, RC_B, 1);
        run_to(SB + 300); want("b_frame_wrap", 1, 0, 0, 1, 1, 1, 1, RC_B, 1);
        run_to(SB + 325); want("b_line1", 1, 0, 1, 1, 1, 1, 0, RC_B, 1);
        run_to(SB + 600); want("b_frame2_wrap", 1, 0, 0, 1, 1, 1, 1, RC_B, 1);
        run_to(SB + 709); want("b_mid_frame", 1, 9, 4, 1, 1, 1, 0, RC_B, 1);

        // asynchronous reset mid-frame, sampled before any further clock edge
        run_to(SB + 710);
        rst_b = 1'b1;
        want("b_async_reset", 1, 0, 0, 0, 1, 1, 0, 0, MR0);
        step(1);
        rst_b = 1'b0;
        edges = 0;
`ifdef MEMCLEAR_EN
        step(1);
        want("b_restart_clear", 1, 0, 0, 0, 1, 1, 0, 1, 0);
        run_to(SB);
        want("b_restart_run", 1, 0, 0, 1, 1, 1, 1, RC_B, 1);
`else
        step(1);
        want("b_restart_run", 1, 0, 0, 1, 1, 1, 1, RC_B, 1);
`endif

        // full-size raster: clear sweep and first line boundaries
        step(1);
        want("a_still_reset", 0, 0, 0, 0, 1, 1, 0, 0, MR0);
        rst_a = 1'b0;
        edges = 0;
`ifdef MEMCLEAR_EN
        step(1);
        want("a_clear_first", 0, 0, 0, 0, 1, 1, 0, 1, 0);
        run_to(799);
        want("a_clear_last", 0, 0, 0, 0, 1, 1, 0, 799, 0);
`endif
        run_to(SA);        want("a_run_entry", 0, 0, 0, 1, 1, 1, 1, RC_A, 1);
        run_to(SA + 1);    want("a_h1", 0, 1, 0, 1, 1, 1, 0, RC_A, 1);
        run_to(SA + 1279); want("a_last_act", 0, 1279, 0, 1, 1, 1, 0, RC_A, 1);
        run_to(SA + 1280); want("a_first_front", 0, 1280, 0, 0, 1, 1, 0, RC_A, 1);
        run_to(SA + 1359); want("a_pre_hsync", 0, 1359, 0, 0, 1, 1, 0, RC_A, 1);
        run_to(SA + 1360); want("a_hsync_beg", 0, 1360, 0, 0, 0, 1, 0, RC_A, 1);
        run_to(SA + 1495); want("a_hsync_end", 0, 1495, 0, 0, 0, 1, 0, RC_A, 1);
        run_to(SA + 1496); want("a_hsync_off", 0, 1496, 0, 0, 1, 1, 0, RC_A, 1);
        run_to(SA + 1711); want("a_line_last", 0, 1711, 0, 0, 1, 1, 0, RC_A, 1);
        run_to(SA + 1712); want("a_line_wrap", 0, 0, 1, 1, 1, 1, 0, RC_A, 1);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
